// File: rtl/vga_scanout_pkg.sv
// Shared timing constants and colour type for the VGA frame-buffer scan-out.
package vga_scanout_pkg;

  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;
  localparam int unsigned FB_W    = 160;
  localparam int unsigned FB_H    = 120;

  typedef logic [2:0] colour_t;

  function automatic logic [9:0] expand_bit(input logic b);
    return {10{b}};
  endfunction

endpackage

// File: rtl/vga_scan_timing.sv
// Pixel-enable generator, h/v scan counters and raw (undelayed) sync/visible flags.
module vga_scan_timing
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VIS = 640,
  parameter int unsigned V_VIS = 480
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       pix_ce_o,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       vis_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       origin_o
);

  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic       pix_ce_q, pix_ce_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  always_comb begin
    pix_ce_d = ~pix_ce_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_ce_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_ce_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_ce_q <= pix_ce_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  assign pix_ce_o = pix_ce_q;
  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign vis_o    = (h_cnt_q < H_VIS_L) && (v_cnt_q < V_VIS_L);
  assign hs_o     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_o     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign origin_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out of a 160x120 3-bit frame buffer with a two-pixel output pipeline.
// Optional colour-bar generator selected by test_mode when VGA_SCANOUT_TEST_PATTERN_EN is defined.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  output logic [14:0] mem_addr,
  input  logic [2:0]  mem_q,
  input  logic        test_mode,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B
);

  logic       pix_ce;
  logic [9:0] h_cnt, v_cnt;
  logic       vis, hs, vs, origin;

  vga_scan_timing #(
    .H_VIS (H_VIS),
    .V_VIS (V_VIS)
  ) u_timing (
    .clk_i    (CLOCK_50),
    .rst_ni   (reset_n),
    .pix_ce_o (pix_ce),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .vis_o    (vis),
    .hs_o     (hs),
    .vs_o     (vs),
    .origin_o (origin)
  );

  logic [7:0] bx;
  logic [6:0] by;
  assign bx = 8'(h_cnt >> SCALE_SHIFT);
  assign by = 7'(v_cnt >> SCALE_SHIFT);

  // Stage 1: address plus the flags that must travel alongside it.
  logic [14:0] mem_addr_q, mem_addr_d;
  logic        vis1_q, hs1_q, vs1_q, fs1_q;

  always_comb begin
    mem_addr_d = mem_addr_q;
    if (vis) begin
      mem_addr_d = 15'(({9'd0, by} << 7) + ({9'd0, by} << 5) + {8'd0, bx});
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      vis1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      fs1_q      <= 1'b0;
    end else if (pix_ce) begin
      mem_addr_q <= mem_addr_d;
      vis1_q     <= vis;
      hs1_q      <= hs;
      vs1_q      <= vs;
      fs1_q      <= origin;
    end
  end

  colour_t col;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic [2:0] bar_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bar_q <= '0;
    end else if (pix_ce) begin
      bar_q <= bx[7:5];
    end
  end

  always_comb begin
    col = colour_t'(mem_q);
    if (test_mode) col = bar_q;
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  always_comb begin
    col = colour_t'(mem_q);
  end
`endif

  // Stage 2: mem_q has been valid for a cycle by the next pix_ce, so colour and syncs land together.
  logic [9:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic       hs2_q, vs2_q, blank_n_q, frame_start_q, vga_clk_q;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vis1_q) begin
      r_d = expand_bit(col[2]);
      g_d = expand_bit(col[1]);
      b_d = expand_bit(col[0]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
    end else begin
      vga_clk_q     <= ~pix_ce;
      frame_start_q <= pix_ce & fs1_q;
      if (pix_ce) begin
        r_q       <= r_d;
        g_q       <= g_d;
        b_q       <= b_d;
        hs2_q     <= hs1_q;
        vs2_q     <= vs1_q;
        blank_n_q <= vis1_q;
      end
    end
  end

  assign mem_addr    = mem_addr_q;
  assign frame_start = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full-size instance for line-level behaviour, reduced instance for frame/vsync.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 640x480
  logic        rst_a_n = 1'b1;
  logic        tm_a = 1'b0;
  logic [14:0] addr_a;
  logic [2:0]  q_a = '0;
  logic        fs_a, vclk_a, hs_a, vs_a, bl_a, sn_a;
  logic [9:0]  r_a, g_a, b_a;

  // Instance B: 64x4 visible, so a whole frame is short
  logic        rst_b_n = 1'b1;
  logic [14:0] addr_b;
  logic [2:0]  q_b = '0;
  logic        fs_b, vclk_b, hs_b, vs_b, bl_b, sn_b;
  logic [9:0]  r_b, g_b, b_b;

  vga_scanout u_a (
    .CLOCK_50(clk), .reset_n(rst_a_n), .mem_addr(addr_a), .mem_q(q_a),
    .test_mode(tm_a), .frame_start(fs_a), .VGA_CLK(vclk_a), .VGA_HS(hs_a),
    .VGA_VS(vs_a), .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sn_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
  );

  vga_scanout #(.H_VIS(64), .V_VIS(4), .SCALE_SHIFT(2)) u_b (
    .CLOCK_50(clk), .reset_n(rst_b_n), .mem_addr(addr_b), .mem_q(q_b),
    .test_mode(1'b0), .frame_start(fs_b), .VGA_CLK(vclk_b), .VGA_HS(hs_b),
    .VGA_VS(vs_b), .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sn_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  function automatic logic [2:0] mem_fn(input logic [14:0] a);
    case (a)
      15'd0:   return 3'b110;
      15'd1:   return 3'b011;
      15'd161: return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  always @(posedge clk) begin
    q_a <= mem_fn(addr_a);
    q_b <= 3'b111;
  end

  typedef struct {
    int unsigned h;
    int unsigned v;
    logic [14:0] addr;
    logic [2:0]  col;
    logic        blank;
    logic        hs;
    logic        vs;
  } row_t;

  row_t tab_a [18];
  row_t tab_p [3];
  row_t tab_b [7];

  int tests = 0;
  int fails = 0;
  int k = 0;
  bit clk_chk = 1'b0;
  int clk_err = 0;
  int fs_a_q[$], hsf_a[$], hsr_a[$];
  int fs_b_q[$], vsf_b[$], vsr_b[$];
  logic hs_a_prev = 1'b1, vs_b_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (clk_chk && (vclk_a !== k[0])) clk_err++;
    if (fs_a) fs_a_q.push_back(k);
    if (fs_b) fs_b_q.push_back(k);
    if (hs_a_prev && !hs_a) hsf_a.push_back(k);
    if (!hs_a_prev && hs_a) hsr_a.push_back(k);
    if (vs_b_prev && !vs_b) vsf_b.push_back(k);
    if (!vs_b_prev && vs_b) vsr_b.push_back(k);
    hs_a_prev = hs_a;
    vs_b_prev = vs_b;
  endtask

  task automatic advance_to(input int target);
    while (k < target) step();
  endtask

  task automatic clear_mon();
    k = 0;
    fs_a_q.delete(); hsf_a.delete(); hsr_a.delete();
    fs_b_q.delete(); vsf_b.delete(); vsr_b.delete();
    hs_a_prev = hs_a;
    vs_b_prev = vs_b;
  endtask

  task automatic run_row(input row_t r, input bit sel_b, input int unsigned htot);
    int p;
    string tag;
    logic [9:0] er, eg, eb;
    p = int'(r.v * htot + r.h);
    tag = $sformatf("%s(%0d,%0d)", sel_b ? "B" : "A", r.h, r.v);
    advance_to(2 * p + 2);
    chk({tag, " mem_addr"}, 32'(sel_b ? addr_b : addr_a), 32'(r.addr));
    advance_to(2 * p + 4);
    er = r.blank ? {10{r.col[2]}} : 10'd0;
    eg = r.blank ? {10{r.col[1]}} : 10'd0;
    eb = r.blank ? {10{r.col[0]}} : 10'd0;
    chk({tag, " R"},       32'(sel_b ? r_b : r_a),   32'(er));
    chk({tag, " G"},       32'(sel_b ? g_b : g_a),   32'(eg));
    chk({tag, " B"},       32'(sel_b ? b_b : b_a),   32'(eb));
    chk({tag, " BLANK_N"}, 32'(sel_b ? bl_b : bl_a), 32'(r.blank));
    chk({tag, " HS"},      32'(sel_b ? hs_b : hs_a), 32'(r.hs));
    chk({tag, " VS"},      32'(sel_b ? vs_b : vs_a), 32'(r.vs));
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, " mem_addr"},    32'(addr_a), 32'd0);
    chk({tag, " frame_start"}, 32'(fs_a),   32'd0);
    chk({tag, " VGA_CLK"},     32'(vclk_a), 32'd0);
    chk({tag, " HS"},          32'(hs_a),   32'd1);
    chk({tag, " VS"},          32'(vs_a),   32'd1);
    chk({tag, " BLANK_N"},     32'(bl_a),   32'd0);
    chk({tag, " SYNC_N"},      32'(sn_a),   32'd1);
    chk({tag, " RGB"},         32'({r_a, g_a}) | 32'(b_a), 32'd0);
  endtask

  initial begin
    tab_a[0]  = '{0,   0, 15'd0,   3'b110, 1'b1, 1'b1, 1'b1};
    tab_a[1]  = '{4,   0, 15'd1,   3'b011, 1'b1, 1'b1, 1'b1};
    tab_a[2]  = '{8,   0, 15'd2,   3'b111, 1'b1, 1'b1, 1'b1};
    tab_a[3]  = '{639, 0, 15'd159, 3'b111, 1'b1, 1'b1, 1'b1};
    tab_a[4]  = '{640, 0, 15'd159, 3'b000, 1'b0, 1'b1, 1'b1};
    tab_a[5]  = '{655, 0, 15'd159, 3'b000, 1'b0, 1'b1, 1'b1};
    tab_a[6]  = '{656, 0, 15'd159, 3'b000, 1'b0, 1'b0, 1'b1};
    tab_a[7]  = '{751, 0, 15'd159, 3'b000, 1'b0, 1'b0, 1'b1};
    tab_a[8]  = '{752, 0, 15'd159, 3'b000, 1'b0, 1'b1, 1'b1};
    tab_a[9]  = '{799, 0, 15'd159, 3'b000, 1'b0, 1'b1, 1'b1};
    tab_a[10] = '{0,   1, 15'd0,   3'b110, 1'b1, 1'b1, 1'b1};
    tab_a[11] = '{4,   4, 15'd161, 3'b101, 1'b1, 1'b1, 1'b1};
    tab_a[12] = '{5,   4, 15'd161, 3'b101, 1'b1, 1'b1, 1'b1};
    tab_a[13] = '{7,   4, 15'd161, 3'b101, 1'b1, 1'b1, 1'b1};
    tab_a[14] = '{8,   4, 15'd162, 3'b111, 1'b1, 1'b1, 1'b1};
    tab_a[15] = '{639, 4, 15'd319, 3'b111, 1'b1, 1'b1, 1'b1};
    tab_a[16] = '{640, 4, 15'd319, 3'b000, 1'b0, 1'b1, 1'b1};
    tab_a[17] = '{0,   5, 15'd160, 3'b111, 1'b1, 1'b1, 1'b1};
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    tab_p[0]  = '{0,   1, 15'd0,   3'b000, 1'b1, 1'b1, 1'b1};
    tab_p[1]  = '{128, 1, 15'd32,  3'b001, 1'b1, 1'b1, 1'b1};
    tab_p[2]  = '{639, 1, 15'd159, 3'b100, 1'b1, 1'b1, 1'b1};
`else
    tab_p[0]  = '{0,   1, 15'd0,   3'b110, 1'b1, 1'b1, 1'b1};
    tab_p[1]  = '{128, 1, 15'd32,  3'b111, 1'b1, 1'b1, 1'b1};
    tab_p[2]  = '{639, 1, 15'd159, 3'b111, 1'b1, 1'b1, 1'b1};
`endif
    tab_b[0]  = '{10,  3, 15'd2,   3'b111, 1'b1, 1'b1, 1'b1};
    tab_b[1]  = '{63,  3, 15'd15,  3'b111, 1'b1, 1'b1, 1'b1};
    tab_b[2]  = '{64,  3, 15'd15,  3'b000, 1'b0, 1'b1, 1'b1};
    tab_b[3]  = '{10,  4, 15'd15,  3'b000, 1'b0, 1'b1, 1'b1};
    tab_b[4]  = '{100, 4, 15'd15,  3'b000, 1'b0, 1'b0, 1'b1};
    tab_b[5]  = '{0,  14, 15'd15,  3'b000, 1'b0, 1'b1, 1'b0};
    tab_b[6]  = '{0,  16, 15'd15,  3'b000, 1'b0, 1'b1, 1'b1};

    // Reset state of both instances
    #2;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("reset");
    chk("B reset HS/VS/BLANK_N/SYNC_N", 32'({hs_b, vs_b, bl_b, sn_b}), 32'b1101);
    chk("B reset RGB/VGA_CLK/fs", 32'({r_b, g_b, b_b, vclk_b, fs_b}), 32'd0);

    // Phase 1: line-level behaviour on A
    @(negedge clk);
    rst_a_n = 1'b1;
    clear_mon();
    clk_chk = 1'b1;
    foreach (tab_a[i]) run_row(tab_a[i], 1'b0, 800);
    clk_chk = 1'b0;
    chk("VGA_CLK phase errors", 32'(clk_err), 32'd0);
    chk("frame_start pulse count", 32'(fs_a_q.size()), 32'd1);
    if (fs_a_q.size() > 0) chk("frame_start edge", 32'(fs_a_q[0]), 32'd4);
    chk("HS fall count >= 2", 32'(hsf_a.size() >= 2), 32'd1);
    if (hsf_a.size() >= 2 && hsr_a.size() >= 1) begin
      chk("HS first fall edge", 32'(hsf_a[0]), 32'd1316);
      chk("HS low cycles", 32'(hsr_a[0] - hsf_a[0]), 32'd192);
      chk("HS period", 32'(hsf_a[1] - hsf_a[0]), 32'd1600);
    end

    // Phase 2: reset mid-frame at counters (300,5)
    advance_to(2 * (5 * 800 + 300));
    rst_a_n = 1'b0;
    #1;
    check_reset_a("mid-reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    tm_a = 1'b1;
    clear_mon();
    check_reset_a("post-release");
    foreach (tab_p[i]) run_row(tab_p[i], 1'b0, 800);
    chk("post-reset frame_start count", 32'(fs_a_q.size()), 32'd1);
    if (fs_a_q.size() > 0) chk("post-reset frame_start edge", 32'(fs_a_q[0]), 32'd4);
    if (hsf_a.size() > 0) chk("post-reset HS first fall", 32'(hsf_a[0]), 32'd1316);
    else chk("post-reset HS fall seen", 32'd0, 32'd1);

    // Phase 3: frame and vsync on the reduced instance
    @(negedge clk);
    rst_b_n = 1'b1;
    clear_mon();
    foreach (tab_b[i]) run_row(tab_b[i], 1'b1, 224);
    while (fs_b_q.size() < 2 && k < 30000) step();
    chk("B frame_start count", 32'(fs_b_q.size()), 32'd2);
    if (fs_b_q.size() >= 2) begin
      chk("B frame_start first edge", 32'(fs_b_q[0]), 32'd4);
      chk("B frame period", 32'(fs_b_q[1] - fs_b_q[0]), 32'd21952);
    end
    if (vsf_b.size() > 0 && vsr_b.size() > 0) begin
      chk("B VS fall edge", 32'(vsf_b[0]), 32'd6276);
      chk("B VS low cycles", 32'(vsr_b[0] - vsf_b[0]), 32'd896);
    end else begin
      chk("B VS pulse seen", 32'd0, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
